load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port load, input, 1 bit: current instruction is a load.
REQ-004 SHALL have port store, input, 1 bit: current instruction is a store.
REQ-005 SHALL have port funct3, input, 3 bits: access size/sign. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store uses 000/001/010 only.
REQ-006 SHALL have port addr, input, 32 bits: effective byte address from ALU.
REQ-007 SHALL have port store_data, input, 32 bits: rs2 value.
REQ-008 SHALL have port data_reg_l, output, 32 bits: formatted load result to the writeback mux.
REQ-009 SHALL have port stall, output, 1 bit: holds PC/pipeline while the access is outstanding.
REQ-010 SHALL have port misaligned, output, 1 bit: one-cycle pulse on an alignment fault.
REQ-011 SHALL have port bus_err, output, 1 bit: one-cycle pulse on an ack timeout.
REQ-012 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_wstrb (out, 4), mem_ack (in, 1) and mem_rdata (in, 32): data-memory side.
REQ-013 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for mem_ack.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ, DONE and ERR.
REQ-015 In IDLE with load or store asserted and the address aligned, SHALL register mem_addr = {addr[31:2], 2'b00}, mem_we = store and the strobe/write data, then enter REQ. Load takes priority if both are asserted.
REQ-016 Alignment rule: halfword needs addr[0]=0, word needs addr[1:0]=00, byte is always aligned. A misaligned access SHALL go IDLE→ERR, SHALL NOT assert mem_req, and SHALL pulse misaligned in ERR.
REQ-017 Store strobes: SB gives 4'b0001<<addr[1:0]. SH gives 4'b0011<<addr[1:0]. SW gives 4'b1111. The store byte/half SHALL be replicated across all lanes of mem_wdata. Load strobe is 4'b1111.
REQ-018 mem_req SHALL be high in REQ only. All mem_* outputs SHALL be stable while mem_req is high.
REQ-019 On mem_ack in REQ, SHALL go to DONE. For a load, SHALL capture into data_reg_l the lane selected by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU). mem_ack outside REQ SHALL be ignored.
REQ-020 Ack latency is zero or more cycles. A wait counter SHALL increment each REQ cycle without mem_ack. When it reaches TIMEOUT, SHALL go to ERR with bus_err, drop mem_req, and leave data_reg_l unchanged.
REQ-021 stall SHALL be combinational: 1 when (state==IDLE and (load or store)) or state==REQ, otherwise 0. stall is therefore 0 in DONE and ERR so the core advances.
REQ-022 DONE and ERR SHALL each last one cycle and then return to IDLE. IDLE SHALL NOT start a new access in the same cycle it is entered from DONE/ERR, which prevents re-issuing the same instruction.
REQ-023 data_reg_l SHALL hold its last load value until the next load completes. Stores SHALL NOT change it.
REQ-024 Unsupported funct3 (011, 110, 111) SHALL be treated as LW/SW.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, data_reg_l=0, misaligned=0, bus_err=0, wait counter=0.
REQ-026 Reset asserted while in REQ SHALL abandon the access with no DONE/ERR pulse. Any later mem_ack SHALL be ignored.

Verification
REQ-027 LB at addr 0x103 with mem_rdata 0x80FF_1234 and ack after 2 cycles → mem_addr 0x100, stall for 3 cycles, data_reg_l 0xFFFF_FF80.
REQ-028 LHU at addr 0x202 with rdata 0xBEEF_0000 and immediate ack → data_reg_l 0x0000_BEEF, stall 2 cycles.
REQ-029 SH at addr 0x12 with store_data 0x0000_ABCD → mem_we 1, mem_wstrb 4'b1100, mem_wdata 0xABCD_ABCD, data_reg_l unchanged.
REQ-030 LW at addr 0x41 → no mem_req, misaligned pulses once, stall 0 in ERR, back in IDLE after one cycle.
REQ-031 LW with mem_ack never asserted, TIMEOUT=4 → mem_req high 4 cycles, bus_err pulses once, data_reg_l unchanged.
REQ-032 rst_n pulsed low mid-REQ, then a late mem_ack → all outputs 0, state IDLE, no capture.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access unit for a scalar core.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   load, store         instruction class (load wins if both are set)
//   funct3              access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//                       (011/110/111 behave as word accesses)
//   addr, store_data    effective byte address and rs2 value
//   data_reg_l          formatted load result, held until the next load completes
//   stall               combinational pipeline hold while an access is pending
//   misaligned, bus_err one-cycle fault pulses (asserted in the ERR cycle)
//   mem_*               registered data-memory request, mem_ack/mem_rdata response
//
// FSM: IDLE -> REQ -> DONE -> IDLE, or IDLE -> ERR (alignment) / REQ -> ERR
// (ack timeout). DONE and ERR are single-cycle, returning to IDLE unconditionally,
// so the instruction that was just serviced can never be re-issued.

// Per-byte-lane store formatting: strobe bit and write byte for lane LANE.
module lsu_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 8
) (
  input  logic [1:0]         size,
  input  logic [1:0]         off,
  input  logic [4*VEC_W-1:0] sd,
  output logic               strb,
  output logic [VEC_W-1:0]   wbyte
);
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] LI   = 2'(LANE);

  always_comb begin
    strb  = 1'b1;
    wbyte = sd[LANE*VEC_W +: VEC_W];
    case (size)
      SZ_B: begin
        // byte replicated to every lane, only the addressed lane strobed
        strb  = (off == LI);
        wbyte = sd[VEC_W-1:0];
      end
      SZ_H: begin
        // halfword replicated to both halves; off[1] picks the strobed half
        strb  = (off[1] == LI[1]);
        wbyte = LI[0] ? sd[2*VEC_W-1:VEC_W] : sd[VEC_W-1:0];
      end
      default: ;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] data_reg_l,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memreq_t;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  memreq_t       req_q, req_d;
  logic [1:0]    ld_size;
  logic          ld_sign;
  logic [1:0]    ld_off;

  // ---- request decode ----
  logic [1:0] size_d;
  logic       misal_d;
  logic [NUM_LANES-1:0]            st_strb;
  logic [NUM_LANES-1:0][VEC_W-1:0] st_wdata;

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_d = SZ_B;
      2'b01:   size_d = SZ_H;
      default: size_d = SZ_W;
    endcase
  end

  assign misal_d = ((size_d == SZ_H) && addr[0]) ||
                   ((size_d == SZ_W) && (addr[1:0] != 2'b00));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane #(.LANE(g), .VEC_W(VEC_W)) u_lane (
      .size  (size_d),
      .off   (addr[1:0]),
      .sd    (store_data),
      .strb  (st_strb[g]),
      .wbyte (st_wdata[g])
    );
  end

  always_comb begin
    req_d.we    = store && !load;
    req_d.addr  = {addr[31:2], 2'b00};
    req_d.wdata = req_d.we ? st_wdata : '0;
    req_d.wstrb = req_d.we ? st_strb  : 4'b1111;
  end

  // ---- load result formatting from the latched size/sign/offset ----
  logic [NUM_LANES-1:0][VEC_W-1:0] rlane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_fmt;

  assign rlane = mem_rdata;
  assign rbyte = rlane[ld_off];
  assign rhalf = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (ld_size)
      SZ_B:    ld_fmt = ld_sign ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      SZ_H:    ld_fmt = ld_sign ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      req_q      <= '0;
      mem_req    <= 1'b0;
      data_reg_l <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      ld_size    <= SZ_W;
      ld_sign    <= 1'b0;
      ld_off     <= 2'b00;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (load || store) begin
            if (misal_d) begin
              misaligned <= 1'b1;
              state      <= ERR;
            end else begin
              req_q    <= req_d;
              mem_req  <= 1'b1;
              wait_cnt <= '0;
              ld_size  <= size_d;
              ld_sign  <= !funct3[2];
              ld_off   <= addr[1:0];
              state    <= REQ;
            end
          end
        end
        REQ: begin
          // ack wins over a timeout expiring in the same cycle
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!req_q.we) data_reg_l <= ld_fmt;
            state   <= DONE;
          end else if (wait_cnt == WLAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;  // DONE, ERR
      endcase
    end
  end

  assign stall     = ((state == IDLE) && (load || store)) || (state == REQ);
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Stimulus pushes expected events into a
// queue; a negedge monitor pops and compares on request issue, completion,
// misaligned and bus_err events, and checks request stability while mem_req is up.
module tb_load_store_unit;
  localparam int K_ISSUE = 0, K_DONE = 1, K_MIS = 2, K_BERR = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load = 0, store = 0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic        mem_ack = 0;
  logic [31:0] data_reg_l, mem_addr, mem_wdata;
  logic        stall, misaligned, bus_err, mem_req, mem_we;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .store(store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .data_reg_l(data_reg_l), .stall(stall),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] dreg;
  } exp_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic exp_issue(logic we, logic [31:0] a, logic [3:0] s, logic [31:0] wd);
    exp_t e;
    e.kind = K_ISSUE; e.we = we; e.addr = a; e.wdata = wd; e.strb = s; e.dreg = '0;
    q.push_back(e);
  endtask

  task automatic exp_ev(int kind, logic [31:0] d);
    exp_t e;
    e.kind = kind; e.we = 0; e.addr = '0; e.wdata = '0; e.strb = '0; e.dreg = d;
    q.push_back(e);
  endtask

  function automatic bit pop(int kind, output exp_t e);
    n_tests++;
    e = '{default: '0};
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d want none at %0t", kind, $time);
      return 0;
    end
    e = q.pop_front();
    if (e.kind != kind) begin
      n_fail++;
      $display("FAIL event_order: got kind %0d want kind %0d at %0t", kind, e.kind, $time);
      return 0;
    end
    return 1;
  endfunction

  // ---- monitor ----
  logic  prev_req = 0, ack_fire = 0;
  exp_t  snap;
  always @(posedge clk) ack_fire <= mem_req && mem_ack;

  always @(negedge clk) begin
    exp_t e;
    if (mem_req && !prev_req) begin
      if (pop(K_ISSUE, e)) begin
        check("issue_we", mem_we, e.we);
        check("issue_addr", mem_addr, e.addr);
        check("issue_wstrb", mem_wstrb, e.strb);
        if (e.we) check("issue_wdata", mem_wdata, e.wdata);
      end
      snap.we = mem_we; snap.addr = mem_addr; snap.wdata = mem_wdata; snap.strb = mem_wstrb;
    end else if (mem_req) begin
      check("req_stable", {mem_we, mem_wstrb, mem_addr[26:0]}, {snap.we, snap.strb, snap.addr[26:0]});
      check("req_stable_wdata", mem_wdata, snap.wdata);
    end
    if (ack_fire && pop(K_DONE, e)) begin
      check("done_data", data_reg_l, e.dreg);
      check("done_stall", stall, 0);
      check("done_flags", {misaligned, bus_err, mem_req}, 0);
    end
    if (misaligned && pop(K_MIS, e)) begin
      check("mis_data", data_reg_l, e.dreg);
      check("mis_stall", stall, 0);
      check("mis_flags", {bus_err, mem_req}, 0);
    end
    if (bus_err && pop(K_BERR, e)) begin
      check("berr_data", data_reg_l, e.dreg);
      check("berr_stall", stall, 0);
      check("berr_flags", {misaligned, mem_req}, 0);
    end
    prev_req = mem_req;
  end

  // ---- stimulus ----
  // lat: REQ cycle index (0 = first) in which mem_ack is driven; -1 = never
  task automatic access(input logic l, s, input logic [2:0] f3, input logic [31:0] a, sd,
                        input int lat, input logic [31:0] rd, input int exp_stall, exp_reqs);
    int stalls = 0, reqs = 0;
    bit done = 0;
    @(negedge clk);
    load = l; store = s; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd; mem_ack = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        mem_ack = (reqs == lat);
        reqs++;
      end else mem_ack = 0;
      if (!stall) done = 1;
      else @(negedge clk);
    end
    load = 0; store = 0; mem_ack = 0;
    check("access_finished", done, 1);
    check("stall_cycles", stalls, exp_stall);
    check("req_cycles", reqs, exp_reqs);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_req, mem_we, mem_wstrb, misaligned, bus_err, stall}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_dreg", data_reg_l, 0);
    rst_n = 1;

    exp_issue(0, 32'h100, 4'hF, 0); exp_ev(K_DONE, 32'hFFFF_FF80);
    access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_1234, 3, 2);
    exp_issue(0, 32'h200, 4'hF, 0); exp_ev(K_DONE, 32'h0000_BEEF);
    access(1, 0, 3'b101, 32'h202, 0, 0, 32'hBEEF_0000, 2, 1);
    exp_issue(1, 32'h10, 4'b1100, 32'hABCD_ABCD); exp_ev(K_DONE, 32'h0000_BEEF);
    access(0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 0, 0, 2, 1);
    exp_ev(K_MIS, 32'h0000_BEEF);
    access(1, 0, 3'b010, 32'h41, 0, 0, 0, 1, 0);
    exp_issue(0, 32'h80, 4'hF, 0); exp_ev(K_BERR, 32'h0000_BEEF);
    access(1, 0, 3'b010, 32'h80, 0, -1, 32'hDEAD_DEAD, 5, 4);
    exp_issue(0, 32'h304, 4'hF, 0); exp_ev(K_DONE, 32'hFFFF_8001);
    access(1, 0, 3'b001, 32'h306, 0, 2, 32'h8001_7FFF, 4, 3);
    exp_issue(0, 32'h100, 4'hF, 0); exp_ev(K_DONE, 32'h0000_00A5);
    access(1, 0, 3'b100, 32'h101, 0, 0, 32'h0000_A500, 2, 1);
    exp_issue(1, 32'h4, 4'b1000, 32'h7878_7878); exp_ev(K_DONE, 32'h0000_00A5);
    access(0, 1, 3'b000, 32'h7, 32'h1234_5678, 1, 0, 3, 2);
    // ack on the last cycle before timeout must still complete
    exp_issue(1, 32'h20, 4'hF, 32'hDEAD_BEEF); exp_ev(K_DONE, 32'h0000_00A5);
    access(0, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 3, 0, 5, 4);
    exp_issue(0, 32'h44, 4'hF, 0); exp_ev(K_DONE, 32'h1122_3344);
    access(1, 0, 3'b011, 32'h44, 0, 0, 32'h1122_3344, 2, 1);
    exp_ev(K_MIS, 32'h1122_3344);
    access(1, 0, 3'b111, 32'h42, 0, 0, 0, 1, 0);
    exp_issue(0, 32'h50, 4'hF, 0); exp_ev(K_DONE, 32'hCAFE_F00D);
    access(1, 1, 3'b010, 32'h50, 32'h0000_FFFF, 0, 32'hCAFE_F00D, 2, 1);
    exp_ev(K_MIS, 32'hCAFE_F00D);
    access(0, 1, 3'b001, 32'h13, 32'h1234, 0, 0, 1, 0);
    exp_issue(0, 32'h8, 4'hF, 0); exp_ev(K_DONE, 32'h8765_4321);
    access(1, 0, 3'b110, 32'h8, 0, 0, 32'h8765_4321, 2, 1);

    // stray ack while idle is ignored
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    mem_ack = 0;
    check("stray_ack_req", mem_req, 0);
    check("stray_ack_dreg", data_reg_l, 32'h8765_4321);

    // reset in the middle of REQ, then a late ack
    exp_issue(0, 32'h60, 4'hF, 0);
    @(negedge clk); load = 1; funct3 = 3'b010; addr = 32'h60;
    repeat (2) @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_flags", {mem_req, mem_we, mem_wstrb, misaligned, bus_err}, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_dreg", data_reg_l, 0);
    load = 0;
    @(negedge clk); rst_n = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    mem_ack = 0;
    check("late_ack_req", {mem_req, stall, misaligned, bus_err}, 0);
    check("late_ack_dreg", data_reg_l, 0);

    exp_issue(0, 32'h0, 4'hF, 0); exp_ev(K_DONE, 32'h0000_00AB);
    access(1, 0, 3'b100, 32'h3, 0, 0, 32'hAB00_0000, 2, 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
